// File: rtl/pdm_mic_decimator.sv
// PDM microphone front end: mclk generation, dual-edge capture,
// box-filter decimation to signed PCM, valid/ready output and PWM monitor.
module pdm_mic_decimator #(
   parameter  int CLK_DIV  = 4,
   parameter  int DEC_LOG2 = 6,
   parameter  int CHANNELS = 2,
   localparam int W        = DEC_LOG2 + 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         dataint,
   input  logic         lr,
   output logic         mclk,
   output logic [W-1:0] pcm_data,
   output logic         pcm_ch,
   output logic         pcm_valid,
   input  logic         pcm_ready,
   output logic         overrun,
   input  logic         ovr_clr,
   output logic         PWM_out
);

   localparam int HALF = CLK_DIV / 2;
   localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int D    = DEC_LOG2;
   localparam int N    = 1 << DEC_LOG2;

   logic [DW-1:0]       div_q, div_d;
   logic                mclk_q, mclk_d;
   logic                s1_q, s2_q;
   logic                lr_q, lr_d, lr_ld_q, lr_ld_d;
   logic [1:0][D:0]     acc_q, acc_d;
   logic [1:0][D-1:0]   cnt_q, cnt_d;
   logic [1:0]          full_q, full_d;
   logic [1:0][W-1:0]   slot_q, slot_d;
   logic                hold_q, hold_d;
   logic                psel_q, psel_d;
   logic                ovr_q, ovr_d;
   logic [D-1:0]        pcnt_q, pcnt_d;
   logic [D:0]          duty_q, duty_d;
   logic [D:0]          pend_q, pend_d;

   logic                tog, lr_eff, sel, xfer;
   logic [1:0]          act, ev, done, take;
   logic [1:0][D:0]     ones;
   logic [1:0][W-1:0]   pcm;

   // Synchroniser carries no reset so it already tracks dataint at release.
   always_ff @(posedge clk) begin
      s1_q <= dataint;
      s2_q <= s1_q;
   end

   always_comb begin
      div_d   = div_q + 1'b1;
      mclk_d  = mclk_q;
      tog     = (div_q == DW'(HALF - 1));
      if (tog) begin
         div_d  = '0;
         mclk_d = ~mclk_q;
      end

      lr_eff  = lr_ld_q ? lr : lr_q;
      act[0]  = (CHANNELS == 2) | ~lr_eff;
      act[1]  = (CHANNELS == 2) | lr_eff;
      ev[0]   = tog & ~mclk_q & act[0];
      ev[1]   = tog & mclk_q & act[1];

      sel     = hold_q ? psel_q : (~full_q[0] & full_q[1]);
      xfer    = (|full_q) & pcm_ready;

      acc_d   = acc_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      slot_d  = slot_q;
      ovr_d   = ovr_q & ~ovr_clr;
      ones    = '0;
      pcm     = '0;
      done    = '0;
      take    = '0;

      for (int c = 0; c < 2; c++) begin
         ones[c] = acc_q[c] + {{D{1'b0}}, s2_q};
         pcm[c]  = {ones[c], 1'b0} - W'(N);
         done[c] = ev[c] & (cnt_q[c] == D'(N - 1));
         take[c] = xfer & (sel == 1'(c));
         if (ev[c]) begin
            acc_d[c] = done[c] ? '0 : ones[c];
            cnt_d[c] = done[c] ? '0 : cnt_q[c] + 1'b1;
         end
         full_d[c] = done[c] | (full_q[c] & ~take[c]);
         if (done[c]) begin
            slot_d[c] = pcm[c];
            if (full_q[c] & ~take[c]) ovr_d = 1'b1;
         end
      end

      hold_d  = (|full_q) & ~pcm_ready;
      psel_d  = sel;

      lr_ld_d = 1'b0;
      lr_d    = (lr_ld_q | (|done)) ? lr : lr_q;

      // New duty waits in pend until the PWM period boundary.
      pcnt_d  = pcnt_q + 1'b1;
      pend_d  = done[0] ? ones[0] : pend_q;
      duty_d  = (&pcnt_q) ? pend_q : duty_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q   <= '0;
         mclk_q  <= 1'b0;
         lr_q    <= 1'b0;
         lr_ld_q <= 1'b1;
         acc_q   <= '0;
         cnt_q   <= '0;
         full_q  <= '0;
         slot_q  <= '0;
         hold_q  <= 1'b0;
         psel_q  <= 1'b0;
         ovr_q   <= 1'b0;
         pcnt_q  <= '0;
         duty_q  <= '0;
         pend_q  <= '0;
      end else begin
         div_q   <= div_d;
         mclk_q  <= mclk_d;
         lr_q    <= lr_d;
         lr_ld_q <= lr_ld_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         slot_q  <= slot_d;
         hold_q  <= hold_d;
         psel_q  <= psel_d;
         ovr_q   <= ovr_d;
         pcnt_q  <= pcnt_d;
         duty_q  <= duty_d;
         pend_q  <= pend_d;
      end
   end

   assign mclk      = mclk_q;
   assign pcm_valid = |full_q;
   assign pcm_ch    = sel;
   assign pcm_data  = slot_q[sel];
   assign overrun   = ovr_q;
   assign PWM_out   = ({1'b0, pcnt_q} < duty_q);

endmodule

// File: doc/pdm_mic_decimator.md
# pdm_mic_decimator

Parametrised PDM microphone front end for the audio path. It generates the microphone bit clock and captures one or two PDM channels on the two edges of that clock, in the standard shared-data-line arrangement. Each channel is decimated with a box (ones-count) filter into signed PCM words, which are delivered over a valid/ready stream. A PWM monitor output tracks channel 0 for direct playback.

## Interface
- CLK_DIV, 4: clk cycles per mclk period; even, ≥2.
- DEC_LOG2, 6: decimation ratio N = 2^DEC_LOG2 PDM bits per PCM sample; range 2..10.
- CHANNELS, 2: 1 = mono (edge chosen by lr), 2 = stereo (both edges).
- Derived: W = DEC_LOG2+2 (PCM width).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dataint  in  1  PDM data from microphone(s); asynchronous to clk.
- lr  in  1  mono only: 0 = capture on mclk rising edge (channel 0), 1 = capture on falling edge (channel 1); ignored when CHANNELS=2.
- mclk  out  1  microphone bit clock.
- pcm_data  out  W  signed PCM sample, two's complement.
- pcm_ch  out  1  channel of pcm_data (0/1).
- pcm_valid  out  1  sample available.
- pcm_ready  in  1  consumer accepts sample.
- overrun  out  1  sticky: a sample was overwritten before being taken.
- ovr_clr  in  1  single-cycle clear of overrun.
- PWM_out  out  1  PWM of latest channel-0 ones count.

## Operation
- Clock divider: counter 0..CLK_DIV/2-1; mclk toggles on the clk edge where the counter equals CLK_DIV/2-1, then the counter wraps to 0.
- dataint passes through a 2-flop synchroniser. The sample event for channel 0 (rise) is the clk cycle in which mclk goes 0→1. The sample event for channel 1 (fall) is the cycle in which mclk goes 1→0. Each event captures the synchronised bit.
- Active channels: stereo = both; mono = the one selected by lr. lr is latched only at a window boundary (reset, or completion of the current window). An lr change mid-window does not take effect until then.
- Per channel: ones accumulator (DEC_LOG2+1 bits) and sample counter (DEC_LOG2 bits). On the N-th sample event, the window completes:
  - ones = acc + bit;
  - pcm = 2·ones − N, a signed W-bit value in −N..+N;
  - pcm is written into that channel's holding slot and the accumulator and counter clear.
- Holding slots: one per channel, each with a full flag.
  - pcm_valid = slot0_full | slot1_full.
  - Slot 0 has priority: pcm_ch/pcm_data come from slot 0 if full, else from slot 1.
  - pcm_data and pcm_ch stay stable while pcm_valid && !pcm_ready.
  - A transfer (valid && ready) empties the presented slot.
- Overrun: if a window completes while its slot is full and the slot is not being transferred in that same cycle, the slot is overwritten with the new sample and overrun is set. If the transfer and the completion hit the same slot in the same cycle, the new sample is loaded, the slot stays full, and no overrun is flagged.
- overrun is sticky until ovr_clr. If ovr_clr and a new overrun coincide, overrun stays set.
- PWM: free-running DEC_LOG2-bit counter on clk. duty (DEC_LOG2+1 bits) loads the channel-0 ones count when a channel-0 window completes, and takes effect at the next counter wrap. PWM_out = (counter < duty): duty N means always high, duty 0 means always low.

## Timing
- Reset (async assert, sync release) values:
  - mclk=0, PWM_out=0, pcm_valid=0, pcm_data=0, pcm_ch=0, overrun=0.
  - All counters, accumulators and slots clear; duty=0; lr latched on the first clk after release.
- First mclk rise: CLK_DIV/2 clk edges after reset release.
- Window completion at event cycle k: the slot is written at edge k+1 and pcm_valid is high from k+1, with no bubble when the output is empty.
- Input latency: 2 clk (synchroniser), plus sampling alignment.
- Reset asserted mid-window or mid-handshake: the partial window and any pending samples are discarded. Capture restarts from an empty state.
- Sustained throughput: one sample per channel per N·CLK_DIV clk cycles. A consumer holding ready low longer than that causes overrun.

## Test plan
- Reset: hold reset=0 for 10 cycles with dataint toggling → all outputs 0 and mclk static. After release, the first mclk rise occurs 2 clk later (CLK_DIV=4).
- Stereo, DEC_LOG2=4 (N=16, W=6), pcm_ready=1, dataint=1 → samples alternate ch0/ch1, each pcm_data=6'b010000 (+16). With dataint=0, each is 6'b110000 (−16).
- Pattern: dataint driven 1 for channel-0 events and 0 for channel-1 events → ch0=+16, ch1=−16. A pattern with 4 ones in 16 → pcm=−8 (6'b111000).
- Mono, lr=1, toggled to 0 mid-window → the current window completes on falling-edge samples (pcm_ch=1). Subsequent samples are pcm_ch=0 only.
- Backpressure: pcm_ready=0 for 3 windows → the first sample is held stable and overrun rises on the second completion for that channel. A single-cycle ovr_clr then clears it, and releasing ready delivers the latest samples, ch0 first.
- PWM: constant dataint=1 → PWM_out is high continuously after the next counter wrap following the first ch0 completion. A 4/16 ones pattern → high for 4 of every 16 clk cycles.
